dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between the ARMv4 core's load/store port and the
//  VGA sprite/frame fetch engine. Sits between top's DataAdr/WriteData/MemWrite path and dmem.
//  Stalls the core while it waits for a grant or for read data.
//  Bounds video bursts so the core is never starved.
// PARAMETERS
//  ADDR_W     12  word-address width of the RAM
//  DATA_W     32  data width
//  VID_BURST  4   max consecutive video grants while CPU waits (>=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high
//  cpu_req     in   1       CPU access request, held until done
//  cpu_we      in   1       1 = store, 0 = load (stable while cpu_req)
//  cpu_addr    in   ADDR_W  CPU word address (stable while cpu_req)
//  cpu_wdata   in   DATA_W  store data
//  cpu_rdata   out  DATA_W  load data, valid when cpu_rvalid
//  cpu_rvalid  out  1       1-cycle pulse: load data returned
//  cpu_stall   out  1       freeze PC/regfile this cycle
//  vid_req     in   1       video read request, held until vid_ack
//  vid_addr    in   ADDR_W  video word address
//  vid_ack     out  1       1-cycle pulse: video read issued to RAM
//  vid_rdata   out  DATA_W  video read data, valid when vid_rvalid
//  vid_rvalid  out  1       1-cycle pulse, exactly one cycle after vid_ack
//  mem_en      out  1       RAM enable
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, 1-cycle latency after mem_en & !mem_we
// BEHAVIOUR
//  - Reset values: all outputs 0. rd_owner=ST_IDLE, streak=0, cpu_pend=0.
//  - Grant is combinational from the inputs plus registered state. At most 1 RAM access per cycle.
//    The winning access drives mem_en/mem_we/mem_addr/mem_wdata in the same cycle.
//  - CPU eligible = cpu_req & !cpu_pend. Video eligible = vid_req (video never writes).
//  - Both eligible: video wins unless streak==VID_BURST, in which case the CPU wins.
//    Only one eligible: it wins. Neither eligible: mem_en=0.
//  - streak increments on a video grant while the CPU is eligible and loses (saturates at
//    VID_BURST). It clears on any CPU grant, or on any cycle the CPU is not eligible.
//  - Read-return FSM (registered owner of the in-flight read):
//    ST_IDLE: no read in flight.
//    ST_CPU: CPU read issued last cycle. cpu_rdata<=mem_rdata, cpu_rvalid=1.
//    ST_VID: video read issued last cycle. vid_rdata<=mem_rdata, vid_rvalid=1.
//    Next state = owner of this cycle's read grant, else ST_IDLE. Back-to-back reads are legal.
//    rdata is steered combinationally from mem_rdata in the return cycle.
//  - cpu_pend sets on a CPU read grant and clears in the cpu_rvalid cycle. It prevents a held
//    cpu_req from re-issuing the same load.
//  - CPU store completes in its grant cycle. CPU load completes in its rvalid cycle.
//  - cpu_stall = cpu_req & !(store granted this cycle | cpu_rvalid).
//  - Worst-case CPU wait = VID_BURST+1 cycles to grant, +1 for load data.
//  - vid_ack asserts only in a video grant cycle. The requester may change vid_addr the next cycle.
//  - cpu_req drop while cpu_pend: the return still completes (cpu_rvalid pulses) and is ignored.
//  - Reset mid-operation: the in-flight return is discarded, no rvalid pulses, and no write
//    is issued while reset is high.
// STRUCTURE
//  - dmem_arb_pkg: typedef enum logic[1:0] {ST_IDLE, ST_CPU, ST_VID} rd_owner_e.
//    It also holds the default ADDR_W/DATA_W constants.
//  - Single flat module. The streak counter is inline (no sub-module warranted).
// TESTING
//  1. CPU store addr 0x019 data 7, no video -> same cycle mem_we=1, mem_addr=0x019,
//     mem_wdata=7, cpu_stall=0.
//  2. CPU load 0x019 with RAM holding 7 -> cycle0 stall=1 & mem_en=1; cycle1 cpu_rvalid=1,
//     cpu_rdata=7, stall=0; no second mem_en for the same load.
//  3. vid_req held continuously and CPU load pending, VID_BURST=4 -> 4 vid_acks, then CPU granted
//     on cycle 5, then video resumes.
//  4. Alternate vid/cpu reads on back-to-back cycles (0x100 video, 0x200 CPU) ->
//     vid_rvalid then cpu_rvalid, each with its own data.
//  5. Assert reset in the cycle after a CPU read grant -> no cpu_rvalid, all outputs 0;
//     after release the held cpu_req re-issues the load.
//  6. Simultaneous CPU store and vid_req with streak==VID_BURST -> the store is written and
//     vid_ack=0 that cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter between the CPU
// load/store port and the video fetch engine.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 12;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_VID_BURST = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_VID  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU loads/stores vs. video reads, with a
// bounded video streak so a waiting CPU access is granted within VID_BURST+1 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned VID_BURST = DEF_VID_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(VID_BURST + 1);

  rd_owner_e             rd_owner_q, rd_owner_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  cpu_pend_q, cpu_pend_d;

  logic cpu_elig;
  logic burst_full;
  logic cpu_win;
  logic vid_win;
  logic store_grant;

  // Grant decision: video has priority until its streak reaches the burst bound.
  always_comb begin
    cpu_elig    = cpu_req & ~cpu_pend_q;
    burst_full  = (streak_q == STREAK_W'(VID_BURST));
    cpu_win     = cpu_elig & (~vid_req | burst_full);
    vid_win     = vid_req & ~cpu_win;
    store_grant = cpu_win & cpu_we;
  end

  // RAM port and requester outputs; everything is held at zero during reset.
  always_comb begin
    mem_en     = ~reset & (cpu_win | vid_win);
    mem_we     = ~reset & store_grant;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!reset && cpu_win) begin
      mem_addr = cpu_addr;
    end else if (!reset && vid_win) begin
      mem_addr = vid_addr;
    end
    if (!reset && store_grant) begin
      mem_wdata = cpu_wdata;
    end
    cpu_rvalid = (rd_owner_q == ST_CPU);
    vid_rvalid = (rd_owner_q == ST_VID);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    vid_rdata  = vid_rvalid ? mem_rdata : '0;
    cpu_stall  = ~reset & cpu_req & ~(store_grant | cpu_rvalid);
    vid_ack    = ~reset & vid_win;
  end

  always_comb begin
    rd_owner_d = ST_IDLE;
    streak_d   = streak_q;
    cpu_pend_d = cpu_pend_q;

    if (cpu_win && !cpu_we) begin
      rd_owner_d = ST_CPU;
    end else if (vid_win) begin
      rd_owner_d = ST_VID;
    end

    if (cpu_win || !cpu_elig) begin
      streak_d = '0;
    end else if (vid_win && !burst_full) begin
      streak_d = streak_q + STREAK_W'(1);
    end

    // A granted load blocks re-issue until its data comes back.
    if (cpu_win && !cpu_we) begin
      cpu_pend_d = 1'b1;
    end else if (cpu_rvalid) begin
      cpu_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_q <= ST_IDLE;
      streak_q   <= '0;
      cpu_pend_q <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      streak_q   <= streak_d;
      cpu_pend_q <= cpu_pend_d;
    end
  end

endmodule
